// File: rtl/add_shift_mult_param.sv
// Sequential add-and-shift multiplier, WIDTH-bit operands, 2*WIDTH-bit {P,A} result.
// Optional two's-complement mode: magnitudes are multiplied and the sign is fixed up at the end.
module add_shift_mult_param #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     ABus,
  input  logic [WIDTH-1:0]     BBus,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   resultBus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    INIT     = 3'd2,
    ADD      = 3'd3,
    SHIFT    = 3'd4,
    FIX      = 3'd5,
    DONE     = 3'd6
  } state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic               sg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] shifted;
  logic [2*WIDTH-1:0] prod_neg;

  // Magnitudes are unsigned, so the most negative operand maps cleanly to 2^(WIDTH-1).
  assign sg       = SIGNED_EN && signed_mode;
  assign mag_a    = (sg && ABus[WIDTH-1]) ? (~ABus + ONE_W) : ABus;
  assign mag_b    = (sg && BBus[WIDTH-1]) ? (~BBus + ONE_W) : BBus;
  assign sum      = {1'b0, p_q} + {1'b0, b_q};
  assign shifted  = {1'b0, carry_q, p_q, a_q} >> 1;
  assign prod_neg = ~{p_q, a_q} + ONE_2W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  // Handshake: start is a level request accepted only while ready=1; the operation
  // launches when start falls, and done pulses for one cycle when the result is valid.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!start) state_d = INIT;
      end
      INIT: begin
        a_d     = mag_a;
        b_d     = mag_b;
        neg_d   = sg && (ABus[WIDTH-1] ^ BBus[WIDTH-1]);
        p_d     = '0;
        carry_d = 1'b0;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        if (a_q[0]) {carry_d, p_d} = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        {carry_d, p_d, a_d} = shifted[2*WIDTH:0];
        cnt_d = cnt_q + CNT_ONE;
        state_d = (cnt_q == CNT_LAST) ? FIX : ADD;
      end
      FIX: begin
        if (neg_q) {p_d, a_d} = prod_neg;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign busy        = (state_q == INIT) || (state_q == ADD) ||
                       (state_q == SHIFT) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign resultBus   = {p_q, a_q};
  assign dbg_state_o = state_q;

endmodule
